decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage of the 16-bit pipelined processor, directly downstream of the fetch stage. It latches each fetched 16-bit word with its 32-bit PC into an IF/ID register and assembles two-word (immediate-carrying) instructions with a small state machine. It reads operands from an 8×16 register file with a write-back port, then drives a registered ID/EX bundle to the execute stage. Stall and flush inputs from hazard control hold or squash the stage.

## Interface
Parameters:
- REG_COUNT, 8: architectural registers; index width is 3.
- DATA_W, 16: register and instruction width.
- ADDR_W, 32: PC width.

Ports:
- clk  input  1  single clock; everything updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- instruction_buf  input  16  fetched word.
- if_pc  input  32  PC of instruction_buf.
- if_valid  input  1  instruction_buf/if_pc hold a real word this cycle.
- stall  input  1  hold IF/ID and FSM, inject bubble into ID/EX.
- flush  input  1  squash IF/ID, FSM and ID/EX; overrides stall.
- wb_en  input  1  register-file write enable.
- wb_addr  input  3  write-back register index.
- wb_data  input  16  write-back data.
- id_valid  output  1  ID/EX bundle holds a real instruction.
- id_opcode  output  5  opcode.
- id_rd, id_rs1, id_rs2  output  3 each  register indices, used by execute for forwarding.
- id_rs1_data, id_rs2_data  output  16 each  operand values.
- id_imm  output  16  immediate; 0 for single-word instructions.
- id_pc  output  32  PC of the instruction's first word.

## Operation
- Word format: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved (ignored). Opcode bit 4 = 1 means a two-word instruction; the next valid word is its 16-bit immediate.
- IF/ID register (ifid_word, ifid_pc, ifid_valid):
  - Loads instruction_buf, if_pc, if_valid each cycle unless stall.
  - On flush, ifid_valid is 0.
- FSM states:
  - FIRST:
    - ifid_valid with a single-word opcode: emit the instruction with imm = 0.
    - ifid_valid with a two-word opcode: copy word and PC to hold registers, go to WAIT_IMM, emit a bubble.
    - ifid_valid = 0: emit a bubble.
  - WAIT_IMM:
    - ifid_valid: emit the held instruction with imm = ifid_word and pc = held PC, go to FIRST.
    - Otherwise stay in WAIT_IMM and emit a bubble.
- Operand read is combinational from the register file, using the rs fields of the word being emitted (held word in WAIT_IMM).
- Write-after-read bypass: if wb_en and wb_addr equals a read index in the same cycle, the read returns wb_data.
- Register file writes on the rising edge when wb_en. All 8 registers are writable; there is no hard-wired zero.
- stall:
  - IF/ID, FSM state and hold registers keep their values.
  - The next ID/EX value is a bubble (id_valid = 0).
  - Operands of the held instruction are re-read every cycle, so write-backs during a stall are never lost.
- flush:
  - Next cycle: ifid_valid = 0, FSM = FIRST, id_valid = 0.
  - A partially assembled two-word instruction is discarded.
- Write-back is independent of stall and flush; a write requested in the same cycle as either still happens.
- Bubble: id_valid = 0. The other ID/EX fields may keep their previous values, and execute ignores them.

## Timing
- Reset values:
  - id_valid = 0; all other ID/EX outputs = 0.
  - ifid_valid = 0; FSM = FIRST; hold registers = 0.
  - All register-file entries = 16'h0000.
- Single-word latency: word presented with if_valid in cycle n, IF/ID loads at edge n+1, ID/EX outputs valid after edge n+2.
- Two-word instructions: the ID/EX outputs are valid one edge after the immediate word reaches IF/ID, which is 3 edges after the first word when the two words are back to back.
- Priority when several apply: rst > flush > stall > normal.
- Reset or flush while in WAIT_IMM returns the FSM to FIRST with no output for the dropped instruction.
- Throughput: one single-word instruction per cycle.

## Structure
- Shared package decode_pkg holds:
  - Field bit positions.
  - Opcode constants, including the two-word flag bit.
  - FSM state encoding: FIRST = 1'b0, WAIT_IMM = 1'b1.
  - Register index width.
- One sub-module, register_file: 8×16, two asynchronous read ports with write bypass, one synchronous write port, synchronous reset.

## Test plan
- Reset and single-word decode:
  - Assert rst for 2 cycles → all outputs 0.
  - Write R2 = 16'h0005 and R3 = 16'h0007, then feed 16'h0A4C (opcode 00001, rd 2, rs1 2, rs2 3) with if_valid.
  - Two edges later: id_valid = 1, id_opcode = 1, id_rs1_data = 5, id_rs2_data = 7, id_imm = 0.
- Two-word instruction: feed 16'h8100 (opcode 10000, rd 1) at PC 0x10, then 16'hBEEF at PC 0x11.
  - One bubble, then id_valid = 1 with id_imm = 16'hBEEF and id_pc = 0x10.
- Stall with write-back: hold stall for 3 cycles while the IF/ID word reads R4, and write R4 = 16'h1234 in the middle cycle.
  - id_valid = 0 for all 3 cycles.
  - After release, the instruction is emitted once with id_rs1_data = 16'h1234.
- Flush in WAIT_IMM: feed 16'h8100, then assert flush together with the immediate word.
  - No valid output results.
  - A following single-word instruction decodes normally from FIRST.
- Bypass: wb_en = 1, wb_addr = 5, wb_data = 16'hA5A5 in the same cycle as decoding an instruction with rs2 = 5 → id_rs2_data = 16'hA5A5.
- Priority: assert stall and flush together → next cycle id_valid = 0, ifid_valid = 0, FSM = FIRST.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction field positions,
// opcode flags, FSM state encoding and the register index width.
package decode_pkg;

  localparam int REG_COUNT = 8;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 32;
  localparam int REG_IDX_W = 3;
  localparam int OPCODE_W  = 5;

  // Instruction word layout: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 5;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 2;

  // Opcode bit 4 set marks an instruction whose next valid word is its immediate.
  localparam logic [OPCODE_W-1:0] OPC_TWO_WORD_FLAG = 5'b10000;

  typedef enum logic {
    ST_FIRST    = 1'b0,
    ST_WAIT_IMM = 1'b1
  } decode_state_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [DATA_W-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_rd(input logic [DATA_W-1:0] w);
    return w[RD_HI:RD_LO];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_rs1(input logic [DATA_W-1:0] w);
    return w[RS1_HI:RS1_LO];
  endfunction

  function automatic logic [REG_IDX_W-1:0] get_rs2(input logic [DATA_W-1:0] w);
    return w[RS2_HI:RS2_LO];
  endfunction

  function automatic logic is_two_word(input logic [DATA_W-1:0] w);
    return (get_opcode(w) & OPC_TWO_WORD_FLAG) != '0;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Bus bundle around the decode stage: fetch inputs, hazard controls,
// write-back port, the registered ID/EX bundle and FSM debug visibility.
//
// Handshake: if_valid and id_valid are valid-only qualifiers. There is no
// ready signal; a word presented with if_valid is taken on the next rising
// edge unless stall holds IF/ID, and id_valid is asserted for exactly one
// cycle per decoded instruction. Execute must sample whenever id_valid = 1.
interface decode_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 3
);
  logic [DATA_W-1:0] instruction_buf;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [IDX_W-1:0]  wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              id_valid;
  logic [4:0]        id_opcode;
  logic [IDX_W-1:0]  id_rd;
  logic [IDX_W-1:0]  id_rs1;
  logic [IDX_W-1:0]  id_rs2;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [ADDR_W-1:0] id_pc;

  logic              dbg_state;
  logic              dbg_ifid_valid;

  // Upstream/environment side: drives fetch, hazard and write-back, observes ID/EX.
  modport master (
    output instruction_buf, if_pc, if_valid, stall, flush, wb_en, wb_addr, wb_data,
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
    input  id_imm, id_pc, dbg_state, dbg_ifid_valid
  );

  // Decode stage side.
  modport slave (
    input  instruction_buf, if_pc, if_valid, stall, flush, wb_en, wb_addr, wb_data,
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_rs1_data, id_rs2_data,
    output id_imm, id_pc, dbg_state, dbg_ifid_valid
  );
endinterface

// File: rtl/decode_register_file.sv
// 8x16 register file: two asynchronous read ports with same-cycle write
// bypass, one synchronous write port, synchronous clear on reset.
module register_file
  import decode_pkg::*;
#(
  parameter int REG_COUNT = 8,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  output logic [DATA_W-1:0]    rdata1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [DATA_W-1:0]    rdata2
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // Storage: clear everything on reset, otherwise write on we.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see a write landing on the same edge so decode never uses stale data.
  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (we && (waddr == raddr1)) rdata1 = wdata;
    if (we && (waddr == raddr2)) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, two-word instruction assembly FSM,
// operand read and the registered ID/EX bundle to execute.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_COUNT = 8,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);

  // IF/ID register
  logic [DATA_W-1:0]    ifid_word;
  logic [ADDR_W-1:0]    ifid_pc;
  logic                 ifid_valid;

  // Assembly FSM and held first word of a two-word instruction
  decode_state_t        state;
  decode_state_t        state_next;
  logic [OPCODE_W-1:0]  hold_opcode;
  logic [REG_IDX_W-1:0] hold_rd;
  logic [REG_IDX_W-1:0] hold_rs1;
  logic [REG_IDX_W-1:0] hold_rs2;
  logic [ADDR_W-1:0]    hold_pc;

  // Instruction selected for emission this cycle
  logic                 emit_valid;
  logic                 capture_hold;
  logic [OPCODE_W-1:0]  emit_opcode;
  logic [REG_IDX_W-1:0] emit_rd;
  logic [REG_IDX_W-1:0] emit_rs1;
  logic [REG_IDX_W-1:0] emit_rs2;
  logic [DATA_W-1:0]    emit_imm;
  logic [ADDR_W-1:0]    emit_pc;
  logic [DATA_W-1:0]    rs1_data;
  logic [DATA_W-1:0]    rs2_data;

  // ID/EX register
  logic                 idex_valid;
  logic [OPCODE_W-1:0]  idex_opcode;
  logic [REG_IDX_W-1:0] idex_rd;
  logic [REG_IDX_W-1:0] idex_rs1;
  logic [REG_IDX_W-1:0] idex_rs2;
  logic [DATA_W-1:0]    idex_rs1_data;
  logic [DATA_W-1:0]    idex_rs2_data;
  logic [DATA_W-1:0]    idex_imm;
  logic [ADDR_W-1:0]    idex_pc;

  logic                 advance;

  assign advance = !bus.stall && !bus.flush;

  // IF/ID: flush squashes the valid bit, stall holds, otherwise load fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_word  <= '0;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else if (bus.flush) begin
      ifid_valid <= 1'b0;
    end else if (!bus.stall) begin
      ifid_word  <= bus.instruction_buf;
      ifid_pc    <= bus.if_pc;
      ifid_valid <= bus.if_valid;
    end
  end

  // FSM state register: flush drops a partial instruction, stall freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FIRST;
    end else if (bus.flush) begin
      state <= ST_FIRST;
    end else if (!bus.stall) begin
      state <= state_next;
    end
  end

  // FSM next state: wait for the immediate after a two-word opcode.
  always_comb begin
    state_next = state;
    case (state)
      ST_FIRST:    if (ifid_valid && is_two_word(ifid_word)) state_next = ST_WAIT_IMM;
      ST_WAIT_IMM: if (ifid_valid) state_next = ST_FIRST;
      default:     state_next = ST_FIRST;
    endcase
  end

  // FSM outputs: pick the instruction to emit and decide when to capture a first word.
  always_comb begin
    emit_valid   = 1'b0;
    capture_hold = 1'b0;
    emit_opcode  = get_opcode(ifid_word);
    emit_rd      = get_rd(ifid_word);
    emit_rs1     = get_rs1(ifid_word);
    emit_rs2     = get_rs2(ifid_word);
    emit_imm     = '0;
    emit_pc      = ifid_pc;
    case (state)
      ST_FIRST: begin
        if (ifid_valid) begin
          if (is_two_word(ifid_word)) capture_hold = 1'b1;
          else                        emit_valid   = 1'b1;
        end
      end
      ST_WAIT_IMM: begin
        emit_valid  = ifid_valid;
        emit_opcode = hold_opcode;
        emit_rd     = hold_rd;
        emit_rs1    = hold_rs1;
        emit_rs2    = hold_rs2;
        emit_imm    = ifid_word;
        emit_pc     = hold_pc;
      end
      default: ;
    endcase
  end

  // Hold registers: keep the first word's fields and PC while the immediate is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_opcode <= '0;
      hold_rd     <= '0;
      hold_rs1    <= '0;
      hold_rs2    <= '0;
      hold_pc     <= '0;
    end else if (capture_hold && advance) begin
      hold_opcode <= get_opcode(ifid_word);
      hold_rd     <= get_rd(ifid_word);
      hold_rs1    <= get_rs1(ifid_word);
      hold_rs2    <= get_rs2(ifid_word);
      hold_pc     <= ifid_pc;
    end
  end

  // Operands are read every cycle, so write-backs during a stall are picked up.
  register_file #(
    .REG_COUNT(REG_COUNT),
    .DATA_W   (DATA_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.wb_en),
    .waddr (bus.wb_addr),
    .wdata (bus.wb_data),
    .raddr1(emit_rs1),
    .rdata1(rs1_data),
    .raddr2(emit_rs2),
    .rdata2(rs2_data)
  );

  // ID/EX: stall and flush inject a bubble; payload only loads with a real instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid    <= 1'b0;
      idex_opcode   <= '0;
      idex_rd       <= '0;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_rs1_data <= '0;
      idex_rs2_data <= '0;
      idex_imm      <= '0;
      idex_pc       <= '0;
    end else if (!advance) begin
      idex_valid <= 1'b0;
    end else begin
      idex_valid <= emit_valid;
      if (emit_valid) begin
        idex_opcode   <= emit_opcode;
        idex_rd       <= emit_rd;
        idex_rs1      <= emit_rs1;
        idex_rs2      <= emit_rs2;
        idex_rs1_data <= rs1_data;
        idex_rs2_data <= rs2_data;
        idex_imm      <= emit_imm;
        idex_pc       <= emit_pc;
      end
    end
  end

  assign bus.id_valid       = idex_valid;
  assign bus.id_opcode      = idex_opcode;
  assign bus.id_rd          = idex_rd;
  assign bus.id_rs1         = idex_rs1;
  assign bus.id_rs2         = idex_rs2;
  assign bus.id_rs1_data    = idex_rs1_data;
  assign bus.id_rs2_data    = idex_rs2_data;
  assign bus.id_imm         = idex_imm;
  assign bus.id_pc          = idex_pc;
  assign bus.dbg_state      = state;
  assign bus.dbg_ifid_valid = ifid_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios with literal expectations
// plus randomized traffic checked against a behavioural pipeline model.
module tb_decode_stage;
  import decode_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_if bus ();

  decode_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected bundle: {full_compare, valid, opcode, rd, rs1, rs2, rs1_data, rs2_data, imm, pc}
  logic [95:0] exp_q[$];

  // Behavioural model state: register contents, the word waiting in IF/ID,
  // and a partially received two-word instruction.
  logic [15:0] m_regs [8];
  logic [15:0] m_ifid_w;
  logic [31:0] m_ifid_pc;
  logic        m_ifid_v;
  logic        m_part;
  logic [15:0] m_part_w;
  logic [31:0] m_part_pc;

  function automatic logic [95:0] pack(input logic full, input logic v, input logic [4:0] op,
                                       input logic [2:0] rd, input logic [2:0] a1, input logic [2:0] a2,
                                       input logic [15:0] d1, input logic [15:0] d2,
                                       input logic [15:0] imm, input logic [31:0] pc);
    return {full, v, op, rd, a1, a2, d1, d2, imm, pc};
  endfunction

  function automatic logic [95:0] bubble();
    return pack(1'b0, 1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 32'd0);
  endfunction

  // One model step for the rising edge that consumes the current inputs.
  task automatic model_step();
    logic [15:0] cw, imm, d1, d2;
    logic [31:0] cpc;
    logic        fire;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_ifid_w = '0; m_ifid_pc = '0; m_ifid_v = 1'b0;
      m_part = 1'b0; m_part_w = '0; m_part_pc = '0;
      exp_q.push_back(pack(1'b1, 1'b0, 5'd0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 32'd0));
    end else begin
      if (m_part) begin
        cw = m_part_w; cpc = m_part_pc; imm = m_ifid_w; fire = m_ifid_v;
      end else begin
        cw = m_ifid_w; cpc = m_ifid_pc; imm = 16'h0; fire = m_ifid_v && !m_ifid_w[15];
      end
      d1 = (bus.wb_en && bus.wb_addr == cw[7:5]) ? bus.wb_data : m_regs[cw[7:5]];
      d2 = (bus.wb_en && bus.wb_addr == cw[4:2]) ? bus.wb_data : m_regs[cw[4:2]];
      if (bus.flush) begin
        exp_q.push_back(bubble());
        m_part = 1'b0;
        m_ifid_v = 1'b0;
      end else if (bus.stall) begin
        exp_q.push_back(bubble());
      end else begin
        if (fire) exp_q.push_back(pack(1'b1, 1'b1, cw[15:11], cw[10:8], cw[7:5], cw[4:2], d1, d2, imm, cpc));
        else      exp_q.push_back(bubble());
        if (fire && m_part) begin
          m_part = 1'b0;
        end else if (!m_part && m_ifid_v && m_ifid_w[15]) begin
          m_part = 1'b1; m_part_w = m_ifid_w; m_part_pc = m_ifid_pc;
        end
        m_ifid_w = bus.instruction_buf; m_ifid_pc = bus.if_pc; m_ifid_v = bus.if_valid;
      end
      if (bus.wb_en) m_regs[bus.wb_addr] = bus.wb_data;
    end
  endtask

  // Scoreboard compare process: every cycle, DUT outputs against the model.
  initial begin
    logic [95:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack(1'b0, bus.id_valid, bus.id_opcode, bus.id_rd, bus.id_rs1, bus.id_rs2,
                 bus.id_rs1_data, bus.id_rs2_data, bus.id_imm, bus.id_pc);
        n_cmp++;
        if (e[95]) begin
          if (a[94:0] !== e[94:0]) begin
            n_err++;
            $display("FAIL model_bundle t=%0t got %h required %h", $time, a[94:0], e[94:0]);
          end
        end else if (a[94] !== e[94]) begin
          n_err++;
          $display("FAIL model_valid t=%0t got %b required %b", $time, a[94], e[94]);
        end
      end
    end
  end

  // Driver: apply inputs, let one rising edge consume them, return at the next falling edge.
  task automatic tick(input logic [15:0] w, input logic [31:0] pc, input logic v,
                      input logic st, input logic fl,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd);
    bus.instruction_buf = w;
    bus.if_pc           = pc;
    bus.if_valid        = v;
    bus.stall           = st;
    bus.flush           = fl;
    bus.wb_en           = we;
    bus.wb_addr         = wa;
    bus.wb_data         = wd;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    tick(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    bus.instruction_buf = '0; bus.if_pc = '0; bus.if_valid = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;

    // Reset for two cycles
    idle();
    idle();
    check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_id_imm", {16'd0, bus.id_imm}, 32'd0);
    check("rst_id_opcode", {27'd0, bus.id_opcode}, 32'd0);
    check("rst_state", {31'd0, bus.dbg_state}, 32'd0);
    check("rst_ifid_valid", {31'd0, bus.dbg_ifid_valid}, 32'd0);
    rst = 1'b0;

    // Single-word decode with operands R2 = 5, R3 = 7
    tick(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0005);
    tick(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0007);
    tick(16'h0A4C, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    idle();
    check("sw_valid", {31'd0, bus.id_valid}, 32'd1);
    check("sw_opcode", {27'd0, bus.id_opcode}, 32'd1);
    check("sw_rd", {29'd0, bus.id_rd}, 32'd2);
    check("sw_rs1_data", {16'd0, bus.id_rs1_data}, 32'h5);
    check("sw_rs2_data", {16'd0, bus.id_rs2_data}, 32'h7);
    check("sw_imm", {16'd0, bus.id_imm}, 32'h0);
    check("sw_pc", bus.id_pc, 32'h100);

    // Two-word instruction back to back
    tick(16'h8100, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick(16'hBEEF, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("tw_bubble", {31'd0, bus.id_valid}, 32'd0);
    check("tw_wait_state", {31'd0, bus.dbg_state}, 32'd1);
    idle();
    check("tw_valid", {31'd0, bus.id_valid}, 32'd1);
    check("tw_opcode", {27'd0, bus.id_opcode}, 32'h10);
    check("tw_rd", {29'd0, bus.id_rd}, 32'd1);
    check("tw_imm", {16'd0, bus.id_imm}, 32'hBEEF);
    check("tw_pc", bus.id_pc, 32'h10);
    idle();

    // Stall for three cycles with R4 written in the middle one
    tick(16'h0880, 32'h50, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick(16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    check("stall_c1", {31'd0, bus.id_valid}, 32'd0);
    tick(16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 16'h1234);
    check("stall_c2", {31'd0, bus.id_valid}, 32'd0);
    tick(16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    check("stall_c3", {31'd0, bus.id_valid}, 32'd0);
    idle();
    check("stall_rel_valid", {31'd0, bus.id_valid}, 32'd1);
    check("stall_rel_rs1_data", {16'd0, bus.id_rs1_data}, 32'h1234);
    check("stall_rel_pc", bus.id_pc, 32'h50);
    idle();
    check("stall_once", {31'd0, bus.id_valid}, 32'd0);

    // Flush while waiting for the immediate
    tick(16'h8100, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick(16'hBEEF, 32'h21, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    check("fl_wait_state", {31'd0, bus.dbg_state}, 32'd1);
    tick(16'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    check("fl_valid", {31'd0, bus.id_valid}, 32'd0);
    check("fl_state", {31'd0, bus.dbg_state}, 32'd0);
    check("fl_ifid_valid", {31'd0, bus.dbg_ifid_valid}, 32'd0);
    idle();
    check("fl_no_output", {31'd0, bus.id_valid}, 32'd0);
    tick(16'h0A4C, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    idle();
    check("fl_after_valid", {31'd0, bus.id_valid}, 32'd1);
    check("fl_after_pc", bus.id_pc, 32'h30);
    check("fl_after_rs1_data", {16'd0, bus.id_rs1_data}, 32'h5);

    // Write bypass on rs2 = R5
    tick(16'h1114, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick(16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'hA5A5);
    check("byp_valid", {31'd0, bus.id_valid}, 32'd1);
    check("byp_rs2", {29'd0, bus.id_rs2}, 32'd5);
    check("byp_rs2_data", {16'd0, bus.id_rs2_data}, 32'hA5A5);
    check("byp_rs1_data", {16'd0, bus.id_rs1_data}, 32'h0);

    // Stall and flush together: flush wins
    tick(16'h0A4C, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    tick(16'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
    check("pri_valid", {31'd0, bus.id_valid}, 32'd0);
    check("pri_ifid_valid", {31'd0, bus.dbg_ifid_valid}, 32'd0);
    check("pri_state", {31'd0, bus.dbg_state}, 32'd0);
    idle();
    check("pri_squashed", {31'd0, bus.id_valid}, 32'd0);

    // Randomized traffic against the model
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      tick(16'($urandom), pc,
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           16'($urandom));
      pc = pc + 32'd1;
    end
    rst = 1'b0;
    idle();
    idle();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
